// File: rtl/id_ex_register.sv
// ID/EX pipeline register. It captures the decode-stage operands, fields and
// control bits and presents them to EX one cycle later. The register file
// writes on the clock edge while its reads are combinational, so a writeback
// in the same cycle to a source register is bypassed into the captured
// operand here. The hazard unit drives STALL (hold) and FLUSH (bubble).
// Two saturating counters record stall and flush events for performance debug.
module id_ex_register #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  STALL,
  input  logic                  FLUSH,
  input  logic                  ValidD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] RdD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [1:0]            ResultSrcD,
  input  logic [2:0]            ALUControlD,
  input  logic                  RegWriteW,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic                  ValidE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [ADDR_WIDTH-1:0] Rs1E,
  output logic [ADDR_WIDTH-1:0] Rs2E,
  output logic [ADDR_WIDTH-1:0] RdE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            ALUControlE,
  output logic [CNT_WIDTH-1:0]  StallCount,
  output logic [CNT_WIDTH-1:0]  FlushCount
);

  logic [DATA_WIDTH-1:0] rd1_fwd;
  logic [DATA_WIDTH-1:0] rd2_fwd;

  // Operand select: x0 always reads zero (so a write to x0 is never
  // forwarded), otherwise a same-cycle writeback overrides the stale read.
  always_comb begin
    rd1_fwd = RD1D;
    rd2_fwd = RD2D;
    if (Rs1D == '0) begin
      rd1_fwd = '0;
    end else if (RegWriteW && (RdW == Rs1D)) begin
      rd1_fwd = ResultW;
    end
    if (Rs2D == '0) begin
      rd2_fwd = '0;
    end else if (RegWriteW && (RdW == Rs2D)) begin
      rd2_fwd = ResultW;
    end
  end

  // Pipeline register: reset and flush both produce the all-zero bubble,
  // stall holds, otherwise load. Held values are never re-bypassed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ValidE      <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
    end else if (FLUSH) begin
      ValidE      <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
    end else if (!STALL) begin
      ValidE      <= ValidD;
      RD1E        <= rd1_fwd;
      RD2E        <= rd2_fwd;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      ImmExtE     <= ImmExtD;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
    end
  end

  // Event counters: a flush cycle counts only as a flush; both stick at
  // all-ones and are cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (FLUSH && (FlushCount != '1)) begin
        FlushCount <= FlushCount + 1'b1;
      end
      if (STALL && !FLUSH && (StallCount != '1)) begin
        StallCount <= StallCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed scenarios from the feature list plus a
// randomized run against a reference model of the E-stage contents.
module tb_id_ex_register;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  // E-stage view, packed so a whole stage compares in one step.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [DW-1:0] pc;
    logic [DW-1:0] pcp4;
    logic [DW-1:0] imm;
    logic          regwrite;
    logic          memwrite;
    logic          jump;
    logic          branch;
    logic          alusrc;
    logic [1:0]    resultsrc;
    logic [2:0]    aluctrl;
  } e_t;

  logic          CLK, RST, STALL, FLUSH, ValidD;
  logic [DW-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD, ResultW;
  logic [AW-1:0] Rs1D, Rs2D, RdD, RdW;
  logic          RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, RegWriteW;
  logic [1:0]    ResultSrcD;
  logic [2:0]    ALUControlD;

  logic          ValidE;
  logic [DW-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [AW-1:0] Rs1E, Rs2E, RdE;
  logic          RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]    ResultSrcE;
  logic [2:0]    ALUControlE;
  logic [CW-1:0] StallCount, FlushCount;

  e_t act;
  e_t exp_e;
  int exp_stall;
  int exp_flush;
  int total;
  int bad;

  id_ex_register #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  assign act = {ValidE, RD1E, RD2E, Rs1E, Rs2E, RdE, PCE, PCPlus4E, ImmExtE,
                RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
                ALUControlE};

  // Clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  // Reference model: what EX should hold after an edge, from the rules alone.
  function automatic logic [DW-1:0] operand(input logic [AW-1:0] rs,
                                            input logic [DW-1:0] rf_data);
    if (rs == 0) return '0;
    if (RegWriteW && RdW == rs) return ResultW;
    return rf_data;
  endfunction

  task automatic model_edge();
    if (RST) begin
      exp_e = '0; exp_stall = 0; exp_flush = 0;
    end else if (FLUSH) begin
      exp_e = '0;
      if (exp_flush < CNTMAX) exp_flush++;
    end else if (STALL) begin
      if (exp_stall < CNTMAX) exp_stall++;
    end else begin
      exp_e.valid     = ValidD;
      exp_e.rd1       = operand(Rs1D, RD1D);
      exp_e.rd2       = operand(Rs2D, RD2D);
      exp_e.rs1       = Rs1D;
      exp_e.rs2       = Rs2D;
      exp_e.rd        = RdD;
      exp_e.pc        = PCD;
      exp_e.pcp4      = PCPlus4D;
      exp_e.imm       = ImmExtD;
      exp_e.regwrite  = RegWriteD;
      exp_e.memwrite  = MemWriteD;
      exp_e.jump      = JumpD;
      exp_e.branch    = BranchD;
      exp_e.alusrc    = ALUSrcD;
      exp_e.resultsrc = ResultSrcD;
      exp_e.aluctrl   = ALUControlD;
    end
  endtask

  // Driver tasks: advance one edge (model follows), settle 1 time unit.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    STALL = 0; FLUSH = 0; ValidD = 0;
    RD1D = '0; RD2D = '0; Rs1D = '0; Rs2D = '0; RdD = '0;
    PCD = '0; PCPlus4D = '0; ImmExtD = '0;
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = '0; ALUControlD = '0;
    RegWriteW = 0; RdW = '0; ResultW = '0;
  endtask

  task automatic drive_random();
    ValidD      = 1'($urandom_range(0, 1));
    RD1D        = $urandom;
    RD2D        = $urandom;
    Rs1D        = AW'($urandom_range(0, 3));
    Rs2D        = AW'($urandom_range(0, 3));
    RdD         = AW'($urandom_range(0, 31));
    PCD         = $urandom;
    PCPlus4D    = $urandom;
    ImmExtD     = $urandom;
    RegWriteD   = 1'($urandom_range(0, 1));
    MemWriteD   = 1'($urandom_range(0, 1));
    JumpD       = 1'($urandom_range(0, 1));
    BranchD     = 1'($urandom_range(0, 1));
    ALUSrcD     = 1'($urandom_range(0, 1));
    ResultSrcD  = 2'($urandom_range(0, 3));
    ALUControlD = 3'($urandom_range(0, 7));
    RegWriteW   = 1'($urandom_range(0, 1));
    RdW         = AW'($urandom_range(0, 3));
    ResultW     = $urandom;
    STALL       = ($urandom_range(0, 3) == 0);
    FLUSH       = ($urandom_range(0, 9) == 0);
  endtask

  task automatic do_reset();
    drive_idle();
    RST = 1;
    tick();
    RST = 0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    do_reset();
    total++;
    if (act !== '0 || StallCount !== 0 || FlushCount !== 0) begin
      bad++;
      $display("FAIL reset_init: got e=%h sc=%0d fc=%0d, want all 0", act, StallCount, FlushCount);
    end
    // Load a value and log a stall, then reset asynchronously mid-cycle.
    Rs1D = 5'd1; RD1D = 32'h12345678; ValidD = 1;
    tick();
    total++;
    if (RD1E !== 32'h12345678) begin
      bad++;
      $display("FAIL reset_preload: got RD1E=%h, want 12345678", RD1E);
    end
    STALL = 1;
    tick();
    drive_idle();
    RST = 1;
    #1;
    exp_e = '0; exp_stall = 0; exp_flush = 0;
    total++;
    if (act !== '0 || StallCount !== 0 || FlushCount !== 0) begin
      bad++;
      $display("FAIL reset_async: got e=%h sc=%0d fc=%0d, want all 0 before edge", act, StallCount, FlushCount);
    end
    #1;
    RST = 0;
  endtask

  task automatic test_stall();
    drive_idle();
    ValidD = 1; PCD = 32'h40;
    tick();
    PCD = 32'h44; STALL = 1;
    // A writeback to the held source must not alter the held operand.
    Rs1D = 5'd2; RegWriteW = 1; RdW = 5'd2; ResultW = 32'hBADBAD00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (PCE !== 32'h40 || RD1E !== 32'h0) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got PCE=%h RD1E=%h, want 40 and 0", i, PCE, RD1E);
      end
    end
    total++;
    if (StallCount !== 3) begin
      bad++;
      $display("FAIL stall_count: got %0d, want 3", StallCount);
    end
    STALL = 0;
    tick();
    total++;
    if (PCE !== 32'h44 || RD1E !== 32'hBADBAD00) begin
      bad++;
      $display("FAIL stall_release: got PCE=%h RD1E=%h, want 44 and badbad00", PCE, RD1E);
    end
  endtask

  task automatic test_plain_load();
    drive_idle();
    ValidD = 1; Rs1D = 5'd3; RD1D = 32'hAAAA0001; RdD = 5'd7;
    RegWriteD = 1; ALUControlD = 3'b010;
    tick();
    total++;
    if (RD1E !== 32'hAAAA0001 || RdE !== 5'd7 || RegWriteE !== 1'b1 ||
        ValidE !== 1'b1 || ALUControlE !== 3'b010) begin
      bad++;
      $display("FAIL plain_load: got RD1E=%h RdE=%0d RW=%b V=%b ALU=%b, want aaaa0001 7 1 1 010",
               RD1E, RdE, RegWriteE, ValidE, ALUControlE);
    end
    total++;
    if (act !== exp_e) begin
      bad++;
      $display("FAIL plain_load_model: got %h, want %h", act, exp_e);
    end
  endtask

  task automatic test_bypass();
    drive_idle();
    ValidD = 1; Rs1D = 5'd5; Rs2D = 5'd5; RD1D = 32'h11; RD2D = 32'h11;
    RegWriteW = 1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    tick();
    total++;
    if (RD1E !== 32'hDEADBEEF || RD2E !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL bypass_both: got RD1E=%h RD2E=%h, want deadbeef", RD1E, RD2E);
    end
    // Write to x0 is never forwarded; x0 reads zero even with RD1D nonzero.
    Rs1D = 5'd0; RdW = 5'd0; RD1D = 32'h55; RD2D = 32'h22;
    tick();
    total++;
    if (RD1E !== 32'h0 || RD2E !== 32'h22) begin
      bad++;
      $display("FAIL bypass_x0: got RD1E=%h RD2E=%h, want 0 and 22", RD1E, RD2E);
    end
    // Bypass gated by write enable.
    Rs1D = 5'd9; RdW = 5'd9; RegWriteW = 0; RD1D = 32'h99;
    tick();
    total++;
    if (RD1E !== 32'h99) begin
      bad++;
      $display("FAIL bypass_noen: got RD1E=%h, want 99", RD1E);
    end
  endtask

  task automatic test_flush_priority();
    int sc0, fc0;
    sc0 = StallCount;
    fc0 = FlushCount;
    drive_idle();
    STALL = 1; FLUSH = 1; RegWriteD = 1; ValidD = 1; PCD = 32'h80; Rs1D = 5'd4; RD1D = 32'h7;
    tick();
    total++;
    if (act !== '0 || FlushCount !== CW'(fc0 + 1) || StallCount !== CW'(sc0)) begin
      bad++;
      $display("FAIL flush_priority: got e=%h fc=%0d sc=%0d, want 0 fc=%0d sc=%0d",
               act, FlushCount, StallCount, fc0 + 1, sc0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    STALL = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (StallCount !== CW'((i < CNTMAX) ? i : CNTMAX)) begin
        bad++;
        $display("FAIL stall_sat[%0d]: got %0d, want %0d", i, StallCount, (i < CNTMAX) ? i : CNTMAX);
      end
    end
    STALL = 0; FLUSH = 1;
    for (int i = 1; i <= 18; i++) tick();
    total++;
    if (FlushCount !== CW'(CNTMAX) || StallCount !== CW'(CNTMAX)) begin
      bad++;
      $display("FAIL flush_sat: got fc=%0d sc=%0d, want %0d both", FlushCount, StallCount, CNTMAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive_random();
      tick();
      total++;
      if (act !== exp_e || StallCount !== CW'(exp_stall) || FlushCount !== CW'(exp_flush)) begin
        bad++;
        $display("FAIL random[%0d]: got e=%h sc=%0d fc=%0d, want e=%h sc=%0d fc=%0d",
                 i, act, StallCount, FlushCount, exp_e, exp_stall, exp_flush);
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    total = 0; bad = 0;
    exp_e = '0; exp_stall = 0; exp_flush = 0;
    RST = 1;
    drive_idle();
    test_reset();
    test_stall();
    test_plain_load();
    test_bypass();
    test_flush_priority();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Decode-to-execute pipeline register of the 5-stage core; captures register-file read data, decode fields and control bits at the end of ID and presents them to EX.
- Contains a WB->ID bypass. The register file writes on the clock edge while reads are combinational, so a same-cycle writeback to a source register must be forwarded into the captured operand.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Carries saturating stall and flush event counters for performance debug.

Parameters:
- DATA_WIDTH, 32, operand/PC/immediate width
- ADDR_WIDTH, 5, register address width
- CNT_WIDTH, 16, width of each performance counter

Ports:
- CLK  in  1  pipeline clock, all state on posedge
- RST  in  1  asynchronous active-high reset
- STALL  in  1  hold all E outputs this cycle
- FLUSH  in  1  load a bubble this cycle
- ValidD  in  1  ID holds a real instruction
- RD1D, RD2D  in  DATA_WIDTH  register-file read data
- Rs1D, Rs2D, RdD  in  ADDR_WIDTH  source and destination register numbers
- PCD, PCPlus4D, ImmExtD  in  DATA_WIDTH  PC, PC+4, extended immediate
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1  control bits
- ResultSrcD  in  2  result select
- ALUControlD  in  3  ALU operation
- RegWriteW  in  1  writeback write enable (same signal as the register file WE3)
- RdW  in  ADDR_WIDTH  writeback address (A3)
- ResultW  in  DATA_WIDTH  writeback data (WD3)
- ValidE, RD1E, RD2E, Rs1E, Rs2E, RdE, PCE, PCPlus4E, ImmExtE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE  out  matching D widths  registered E-stage copies
- StallCount, FlushCount  out  CNT_WIDTH  saturating event counters

Behaviour:
- Reset: RST high asynchronously forces every output, including both counters, to 0. The all-zero state is a bubble (ValidE=0, RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0). Deassertion takes effect at the next posedge.
- Update priority per posedge: RST > FLUSH > STALL > load.
- Load (FLUSH=0, STALL=0):
  - Every E output takes its D input; latency 1 cycle.
  - RD1E = 0 if Rs1D==0.
  - Otherwise RD1E = ResultW if RegWriteW=1 and RdW==Rs1D; else RD1D.
  - RD2E uses the same rule with Rs2D.
  - x0 check has priority over the bypass: a write to RdW=0 is never forwarded.
- Flush (FLUSH=1, either STALL value): all E outputs cleared to 0, identical to the reset state. D inputs are discarded.
- Stall (STALL=1, FLUSH=0): all E outputs hold their values. The bypass is not applied to held values; the hazard unit guarantees held operands are still correct.
- ValidE is loaded from ValidD; invalid instructions pass through unchanged. Gating control bits with ValidD is the decoder's job.
- StallCount increments by 1 on each posedge with STALL=1 and FLUSH=0.
- FlushCount increments by 1 on each posedge with FLUSH=1.
- Both counters saturate at all-ones and never wrap. They are cleared only by RST.
- Same-cycle write and read of the same register, both operands, resolves to ResultW for both RD1E and RD2E.
- RST asserted mid-stall clears all state immediately; the held instruction is lost.

Test Plan:
- Reset: RST=1 mid-operation with RD1E=0x12345678 -> all outputs 0 immediately, before the next CLK edge; counters 0.
- Plain load: ValidD=1, Rs1D=3, RD1D=0xAAAA0001, RdD=7, RegWriteD=1, ALUControlD=3'b010, RegWriteW=0 -> next cycle RD1E=0xAAAA0001, RdE=7, RegWriteE=1, ValidE=1.
- Bypass: Rs1D=5, Rs2D=5, RD1D=RD2D=0x11, RegWriteW=1, RdW=5, ResultW=0xDEADBEEF -> RD1E=RD2E=0xDEADBEEF. Repeat with RdW=0, Rs1D=0 -> RD1E=0.
- Stall: load PCD=0x40, then STALL=1 for 3 cycles while PCD=0x44 -> PCE stays 0x40 for 3 cycles; StallCount=3; then PCE=0x44.
- Flush priority: STALL=1, FLUSH=1, RegWriteD=1, ValidD=1 -> ValidE=0, RegWriteE=0, all fields 0; FlushCount+1, StallCount unchanged.
- Saturation with CNT_WIDTH=4: 20 stall cycles -> StallCount=15 and holds at 15.
